bcd_convert_seq: RTL

BCD_CONVERT_SEQ -- requirements
Module: bcd_convert_seq

---
 rtl/bcd_convert_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: sequential binary-to-BCD converter using the shift-and-add-3
// (double dabble) algorithm, one input bit per clock.
//
// Parameters:
//   IN_W  binary input width in bits
//   NDIG  number of BCD digits produced (4 bits each)
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     request a conversion of bin (ignored while busy)
//   bin       unsigned binary value, sampled only when start is accepted
//   busy      high while a conversion is in progress (SHIFT or FINISH)
//   done      one-cycle pulse marking the update of digits/overflow
//   digits    packed BCD result, digit 0 in bits [3:0]
//   overflow  last result exceeded 10^NDIG-1 (digits then read all nines)
module bcd_convert_seq #(
  parameter int unsigned IN_W = 32,
  parameter int unsigned NDIG = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_W-1:0]     bin,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   digits,
  output logic                overflow
);

  localparam int unsigned DigW = 4 * NDIG;
  localparam int unsigned CntW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [DigW-1:0]   acc_q, acc_d;
  logic              acc_ovf_q, acc_ovf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DigW-1:0]   digits_q, digits_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  // Accumulator after the add-3 correction of every digit >= 5.
  logic [DigW-1:0]   acc_adj;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    acc_ovf_d  = acc_ovf_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          bin_d     = bin;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          cnt_d     = CntW'(IN_W);
          state_d   = StShift;
        end
      end
      StShift: begin
        acc_d = {acc_adj[DigW-2:0], bin_q[IN_W-1]};
        bin_d = bin_q << 1;
        // A carry out of the top digit means the value no longer fits.
        if (acc_adj[DigW-1]) begin
          acc_ovf_d = 1'b1;
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        // Outputs are only touched here so the display never sees partial sums.
        digits_d   = acc_ovf_q ? {NDIG{4'h9}} : acc_q;
        overflow_d = acc_ovf_q;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      cnt_q      <= '0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      acc_ovf_q  <= acc_ovf_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign digits   = digits_q;
  assign overflow = overflow_q;

endmodule
